// File: rtl/latch.sv
`timescale 1ns/1ps
// latch: level-sensitive gated D latch with asynchronous active-low clear
// Transparent while clk equals GATE_HIGH; holds otherwise; clear wins over the gate.
module latch #(
   parameter int               WIDTH       = 1,
   parameter bit               GATE_HIGH   = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] din,
   input  logic             reset,
   output logic [WIDTH-1:0] dout
);
   always_latch
      if (!reset) dout <= RESET_VALUE;
      else if (clk == GATE_HIGH) dout <= din;
endmodule

// File: tb/tb_latch.sv
`timescale 1ns/1ps
// tb_latch: checks a default 1-bit latch and an 8-bit transparent-low latch
// against a held-value reference model driven with directed and random stimulus.
module tb_latch;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       din = 1'b0;
   logic [7:0] din8 = 8'h00;
   logic       dout;
   logic [7:0] dout8;
   int         errors = 0;
   int         checks = 0;
   // A capture racing the closing gate may legally land on either value
   logic       e1a, e1b;
   logic [7:0] e8a, e8b;

   latch u_dut (.clk(clk), .din(din), .reset(reset), .dout(dout));
   latch #(.WIDTH(8), .GATE_HIGH(1'b0), .RESET_VALUE(8'hA5)) u_p8 (
      .clk(clk), .din(din8), .reset(reset), .dout(dout8));

   task automatic drive(input logic c, input logic r, input logic d, input logic [7:0] d8);
      logic       pc = clk;
      logic       pr = reset;
      logic       pd = din;
      logic [7:0] pd8 = din8;
      clk = c;
      reset = r;
      din = d;
      din8 = d8;
      if (!r) begin
         e1a = 1'b0; e1b = 1'b0; e8a = 8'hA5; e8b = 8'hA5;
      end else begin
         if (c) begin
            e1a = d; e1b = d;
         end else if (pc && pr && d !== pd) begin
            e1a = pd; e1b = d;
         end
         if (!c) begin
            e8a = d8; e8b = d8;
         end else if (!pc && pr && d8 !== pd8) begin
            e8a = pd8; e8b = d8;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      for (int t = 0; t < 60; t++) begin
         drive((t % 10) < 5, 1'b0, ((t / 13) % 2) == 1, 8'($urandom));
         checks++;
         if (dout !== 1'b0) begin
            errors++;
            $display("FAIL reset t=%0d dout=%b expected=0", t, dout);
         end
         checks++;
         if (dout8 !== 8'hA5) begin
            errors++;
            $display("FAIL reset8 t=%0d dout8=%h expected=a5", t, dout8);
         end
      end
   endtask

   task automatic test_transparency();
      logic [2:0] pat = 3'b010;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, pat[i], din8);
         checks++;
         if (dout !== pat[i]) begin
            errors++;
            $display("FAIL transparency step=%0d dout=%b expected=%b", i, dout, pat[i]);
         end
         #1;
      end
   endtask

   task automatic test_hold();
      drive(1'b1, 1'b1, 1'b1, din8);
      drive(1'b0, 1'b1, 1'b1, din8);
      drive(1'b0, 1'b1, 1'b0, din8);
      checks++;
      if (dout !== 1'b1) begin
         errors++;
         $display("FAIL hold_din_low dout=%b expected=1", dout);
      end
      drive(1'b0, 1'b1, 1'b1, din8);
      drive(1'b0, 1'b1, 1'b0, din8);
      checks++;
      if (dout !== 1'b1) begin
         errors++;
         $display("FAIL hold_toggle dout=%b expected=1", dout);
      end
      drive(1'b1, 1'b1, 1'b0, din8);
      checks++;
      if (dout !== 1'b0) begin
         errors++;
         $display("FAIL hold_reopen dout=%b expected=0", dout);
      end
   endtask

   task automatic test_clear_mid_hold();
      drive(1'b1, 1'b1, 1'b1, din8);
      drive(1'b0, 1'b1, 1'b1, din8);
      checks++;
      if (dout !== 1'b1) begin
         errors++;
         $display("FAIL clear_pre dout=%b expected=1", dout);
      end
      drive(1'b0, 1'b0, 1'b1, din8);
      checks++;
      if (dout !== 1'b0) begin
         errors++;
         $display("FAIL clear_immediate dout=%b expected=0", dout);
      end
      #2;
      drive(1'b0, 1'b1, 1'b1, din8);
      #2;
      checks++;
      if (dout !== 1'b0) begin
         errors++;
         $display("FAIL clear_released_closed dout=%b expected=0", dout);
      end
      drive(1'b1, 1'b1, 1'b1, din8);
      checks++;
      if (dout !== 1'b1) begin
         errors++;
         $display("FAIL clear_next_open dout=%b expected=1", dout);
      end
   endtask

   task automatic test_free_run();
      logic [7:0] d8 = din8;
      for (int t = 0; t < 600; t++) begin
         if (t % 13 == 0) d8 = 8'($urandom);
         drive((t % 10) < 5, ((t / 200) % 2) == 0, ((t / 13) % 2) == 1, d8);
         checks++;
         if (dout !== e1a && dout !== e1b) begin
            errors++;
            $display("FAIL free_run t=%0d dout=%b expected=%b/%b", t, dout, e1a, e1b);
         end
         checks++;
         if (dout8 !== e8a && dout8 !== e8b) begin
            errors++;
            $display("FAIL free_run8 t=%0d dout8=%h expected=%h/%h", t, dout8, e8a, e8b);
         end
      end
   endtask

   task automatic test_params();
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      checks++;
      if (dout8 !== 8'hA5) begin
         errors++;
         $display("FAIL param_reset dout8=%h expected=a5", dout8);
      end
      drive(1'b0, 1'b1, 1'b0, 8'h3C);
      checks++;
      if (dout8 !== 8'h3C) begin
         errors++;
         $display("FAIL param_open_low dout8=%h expected=3c", dout8);
      end
      drive(1'b1, 1'b1, 1'b0, 8'h3C);
      drive(1'b1, 1'b1, 1'b0, 8'hFF);
      checks++;
      if (dout8 !== 8'h3C) begin
         errors++;
         $display("FAIL param_hold_high dout8=%h expected=3c", dout8);
      end
      drive(1'b0, 1'b1, 1'b0, 8'hFF);
      checks++;
      if (dout8 !== 8'hFF) begin
         errors++;
         $display("FAIL param_reopen dout8=%h expected=ff", dout8);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic       c = clk;
         logic       r = reset;
         logic       d = din;
         logic [7:0] d8 = din8;
         case ($urandom_range(0, 3))
            0: c = !c;
            1: r = $urandom_range(0, 7) != 0;
            2: d = 1'($urandom);
            default: d8 = 8'($urandom);
         endcase
         drive(c, r, d, d8);
         checks++;
         if (dout !== e1a && dout !== e1b) begin
            errors++;
            $display("FAIL random i=%0d dout=%b expected=%b", i, dout, e1a);
         end
         checks++;
         if (dout8 !== e8a && dout8 !== e8b) begin
            errors++;
            $display("FAIL random8 i=%0d dout8=%h expected=%h", i, dout8, e8a);
         end
      end
   endtask

   initial begin
      test_reset();
      test_transparency();
      test_hold();
      test_clear_mid_hold();
      test_free_run();
      test_params();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
